next_pc_unit: RTL and testbench



---
 rtl/mp_pkg.sv | 25 ++
 rtl/next_pc_unit_ras_stack.sv | 57 +++++
 rtl/next_pc_unit.sv | 133 +++++++++++++
 tb/tb_next_pc_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared constants and encodings for the next-PC path (decode, debug and the
// next-address generator all agree on these).
package mp_pkg;

  localparam int AW = 8;
  localparam logic [AW-1:0] RESET_VEC = 8'h00;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  // Next-PC source select
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_JMP,
    SEL_BR,
    SEL_RET,
    SEL_VEC
  } sel_e;

endpackage

// File: rtl/next_pc_unit_ras_stack.sv
// Return-address stack: DEPTH x AW LIFO. A push and a pop in the same cycle
// is treated as a pop only. Push when full and pop when empty are dropped;
// the caller flags those as errors.
module ras_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              din,
  output logic [AW-1:0]              top,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW:0]   sp_q;
  logic [PW:0]   sp_d;
  logic          do_push;
  logic          do_pop;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] top_idx;

  assign full    = (sp_q == (PW+1)'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !pop && !full;
  // When full the low bits wrap to zero, so top_idx still lands on DEPTH-1.
  assign wr_idx  = sp_q[PW-1:0];
  assign top_idx = sp_q[PW-1:0] - PW'(1);
  assign top     = mem_q[top_idx];
  assign depth   = sp_q;

  // Next stack-pointer value
  always_comb begin
    sp_d = sp_q;
    if (do_pop)       sp_d = sp_q - (PW+1)'(1);
    else if (do_push) sp_d = sp_q + (PW+1)'(1);
  end

  // Stack pointer; contents are left untouched by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // Entry storage written on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-address generator feeding the pc register. next_pc is combinational
// from the sequencer state and this cycle's controls; the pc register adds
// the one-cycle delay.
module next_pc_unit
  import mp_pkg::*;
#(
  parameter int              AW        = mp_pkg::AW,
  parameter int              DEPTH     = 4,
  parameter logic [AW-1:0]   RESET_VEC = mp_pkg::RESET_VEC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AW-1:0]          pc_cur,
  input  logic                   stall,
  input  logic                   jmp,
  input  logic                   br,
  input  logic                   br_taken,
  input  logic [AW-1:0]          br_off,
  input  logic [AW-1:0]          tgt_addr,
  input  logic                   call,
  input  logic                   ret,
  input  logic                   halt,
  input  logic                   resume,
  output logic [AW-1:0]          next_pc,
  output logic [$clog2(DEPTH):0] sp_depth,
  output logic                   err_ovf,
  output logic                   err_unf,
  output logic                   halted
);

  state_e        state_q, state_d;
  sel_e          sel;
  logic          push, pop, set_ovf, set_unf;
  logic          stk_full, stk_empty;
  logic [AW-1:0] stk_top;
  logic [AW-1:0] pc_inc;
  logic          err_ovf_q, err_unf_q;

  // Increment and branch add both wrap modulo 2^AW; the offset is already
  // AW-bit two's complement so a plain add sign-extends for free.
  assign pc_inc = pc_cur + AW'(1);

  ras_stack #(.AW(AW), .DEPTH(DEPTH)) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .depth (sp_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Control decode: select source, stack ops, error sets and next state
  always_comb begin
    sel     = SEL_INC;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    state_d = state_q;
    case (state_q)
      BOOT: begin
        sel     = SEL_VEC;
        state_d = RUN;
      end
      RUN: begin
        if (halt) begin
          sel     = SEL_HOLD;
          state_d = HALT;
        end else if (stall) begin
          sel = SEL_HOLD;
        end else if (ret) begin
          if (!stk_empty) begin
            sel = SEL_RET;
            pop = 1'b1;
          end else begin
            sel     = SEL_INC;
            set_unf = 1'b1;
          end
        end else if (call) begin
          sel = SEL_JMP;
          if (!stk_full) push = 1'b1;
          else           set_ovf = 1'b1;
        end else if (jmp) begin
          sel = SEL_JMP;
        end else if (br && br_taken) begin
          sel = SEL_BR;
        end
      end
      HALT: begin
        sel = SEL_HOLD;
        if (resume) state_d = RUN;
      end
      default: begin
        sel     = SEL_VEC;
        state_d = BOOT;
      end
    endcase
  end

  // Next-PC source mux
  always_comb begin
    next_pc = RESET_VEC;
    case (sel)
      SEL_HOLD: next_pc = pc_cur;
      SEL_INC:  next_pc = pc_inc;
      SEL_JMP:  next_pc = tgt_addr;
      SEL_BR:   next_pc = pc_cur + br_off;
      SEL_RET:  next_pc = stk_top;
      default:  next_pc = RESET_VEC;
    endcase
  end

  // Sequencer state and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_ovf_q <= err_ovf_q | set_ovf;
      err_unf_q <= err_unf_q | set_unf;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: inputs change on the falling edge and
// outputs are sampled shortly after, well clear of the rising edge.
module tb_next_pc_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pc_cur;
  logic       stall, jmp, br, br_taken, call, ret, halt, resume;
  logic [7:0] br_off, tgt_addr;
  logic [7:0] next_pc;
  logic [2:0] sp_depth;
  logic       err_ovf, err_unf, halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  next_pc_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_cur   (pc_cur),
    .stall    (stall),
    .jmp      (jmp),
    .br       (br),
    .br_taken (br_taken),
    .br_off   (br_off),
    .tgt_addr (tgt_addr),
    .call     (call),
    .ret      (ret),
    .halt     (halt),
    .resume   (resume),
    .next_pc  (next_pc),
    .sp_depth (sp_depth),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf),
    .halted   (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; jmp = 0; br = 0; br_taken = 0; call = 0; ret = 0;
    halt = 0; resume = 0; br_off = 8'h00; tgt_addr = 8'h00;
  endtask

  // One rising edge, then back to the falling edge for the next vector
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a call at pc and check next_pc is the target, then clock it
  task automatic do_call(input logic [7:0] pc, input logic [7:0] tgt, input string tag);
    idle(); pc_cur = pc; call = 1; tgt_addr = tgt;
    #2 chk(tag, next_pc, tgt);
    cycle();
  endtask

  // Present a ret and check the returned address, then clock it
  task automatic do_ret(input logic [7:0] pc, input logic [7:0] exp, input string tag);
    idle(); pc_cur = pc; ret = 1;
    #2 chk(tag, next_pc, exp);
    cycle();
  endtask

  initial begin
    idle();
    rst_n  = 0;
    pc_cur = 8'h00;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_next_pc", next_pc, 8'h00);
    chk("rst_sp", sp_depth, 3'd0);
    chk("rst_ovf", err_ovf, 1'b0);
    chk("rst_unf", err_unf, 1'b0);
    chk("rst_halted", halted, 1'b0);
    $display("reset held: next_pc=%0h", next_pc);

    // Boot: vector for one cycle, then sequential
    @(negedge clk);
    rst_n = 1;
    #2 chk("boot_vec", next_pc, 8'h00);
    cycle();
    #2 chk("run_inc", next_pc, 8'h01);
    chk("run_flags", {err_ovf, err_unf, halted}, 3'b000);
    $display("boot: next_pc=%0h", next_pc);

    // Wrap and branch
    pc_cur = 8'hFF;
    #2 chk("wrap_inc", next_pc, 8'h00);
    pc_cur = 8'h02; br = 1; br_taken = 1; br_off = 8'hFC;
    #2 chk("br_taken_neg", next_pc, 8'hFE);
    br_taken = 0;
    #2 chk("br_not_taken", next_pc, 8'h03);
    br = 0; br_taken = 1;
    #2 chk("taken_without_br", next_pc, 8'h03);
    br = 1; br_off = 8'h05;
    #2 chk("br_taken_pos", next_pc, 8'h07);
    idle(); pc_cur = 8'h10; jmp = 1; tgt_addr = 8'h5A; br = 1; br_taken = 1; br_off = 8'h01;
    #2 chk("jmp_over_br", next_pc, 8'h5A);
    $display("wrap/branch/jmp vectors done");
    cycle();

    // Call/return nesting
    do_call(8'h10, 8'h40, "call1");
    chk("call1_sp", sp_depth, 3'd1);
    do_call(8'h20, 8'h40, "call2");
    chk("call2_sp", sp_depth, 3'd2);
    do_call(8'h30, 8'h40, "call3");
    chk("call3_sp", sp_depth, 3'd3);
    do_ret(8'h40, 8'h31, "ret1");
    chk("ret1_sp", sp_depth, 3'd2);
    do_ret(8'h41, 8'h21, "ret2");
    chk("ret2_sp", sp_depth, 3'd1);
    do_ret(8'h42, 8'h11, "ret3");
    chk("ret3_sp", sp_depth, 3'd0);
    chk("nest_errs", {err_ovf, err_unf}, 2'b00);
    $display("nesting: sp_depth=%0d", sp_depth);

    // Overflow
    for (int i = 0; i < 4; i++) do_call(8'h60 + 8'(i), 8'h80, "ovf_fill");
    chk("ovf_full_sp", sp_depth, 3'd4);
    chk("ovf_not_yet", err_ovf, 1'b0);
    do_call(8'h64, 8'h80, "ovf_call5");
    chk("ovf_flag", err_ovf, 1'b1);
    chk("ovf_sp", sp_depth, 3'd4);
    do_ret(8'h80, 8'h64, "ovf_ret_top");
    chk("ovf_ret_sp", sp_depth, 3'd3);
    do_ret(8'h81, 8'h63, "ovf_ret2");
    do_ret(8'h82, 8'h62, "ovf_ret3");
    do_ret(8'h83, 8'h61, "ovf_ret4");
    chk("ovf_drain_sp", sp_depth, 3'd0);
    chk("ovf_no_unf", err_unf, 1'b0);
    $display("overflow: err_ovf=%0b", err_ovf);

    // Underflow
    do_ret(8'h50, 8'h51, "unf_ret");
    chk("unf_flag", err_unf, 1'b1);
    chk("unf_sp", sp_depth, 3'd0);
    idle(); pc_cur = 8'h58; call = 1; ret = 1; tgt_addr = 8'h99;
    #2 chk("callret_empty", next_pc, 8'h59);
    cycle();
    chk("callret_empty_sp", sp_depth, 3'd0);
    $display("underflow: err_unf=%0b", err_unf);

    // Stall and call/ret priority
    do_call(8'h76, 8'h90, "push77");
    idle(); pc_cur = 8'h22; stall = 1; call = 1; jmp = 1; tgt_addr = 8'h44;
    #2 chk("stall_hold", next_pc, 8'h22);
    cycle();
    chk("stall_call_sp", sp_depth, 3'd1);
    call = 0; jmp = 0; ret = 1;
    #2 chk("stall_ret_hold", next_pc, 8'h22);
    cycle();
    chk("stall_ret_sp", sp_depth, 3'd1);
    idle(); pc_cur = 8'h90; call = 1; ret = 1; tgt_addr = 8'hAA;
    #2 chk("callret_pop", next_pc, 8'h77);
    cycle();
    chk("callret_sp", sp_depth, 3'd0);

    // Pushed return address wraps
    do_call(8'hFF, 8'h12, "call_wrap");
    do_ret(8'h12, 8'h00, "ret_wrap");
    $display("stall/priority/wrap-push done");

    // Halt with toggling controls, then resume
    idle(); pc_cur = 8'h33; halt = 1;
    #2 chk("halt_enter", next_pc, 8'h33);
    cycle();
    chk("halted_set", halted, 1'b1);
    halt = 0; jmp = 1; tgt_addr = 8'h99;
    #2 chk("halt_ign_jmp", next_pc, 8'h33);
    cycle();
    jmp = 0; call = 1;
    #2 chk("halt_ign_call", next_pc, 8'h33);
    cycle();
    chk("halt_no_push", sp_depth, 3'd0);
    call = 0; resume = 1;
    #2 chk("resume_cycle", next_pc, 8'h33);
    chk("resume_still_halted", halted, 1'b1);
    cycle();
    idle();
    #2 chk("resumed", halted, 1'b0);
    chk("resumed_inc", next_pc, 8'h34);
    $display("halt/resume: halted=%0b", halted);
    cycle();

    // Asynchronous reset mid-operation while halted with two entries
    do_call(8'h05, 8'h40, "pre_rst_c1");
    do_call(8'h06, 8'h40, "pre_rst_c2");
    idle(); pc_cur = 8'h33; halt = 1;
    cycle();
    chk("pre_rst_halted", halted, 1'b1);
    chk("pre_rst_sp", sp_depth, 3'd2);
    halt = 0; call = 1;
    #2 rst_n = 0;
    #1;
    chk("arst_next_pc", next_pc, 8'h00);
    chk("arst_sp", sp_depth, 3'd0);
    chk("arst_halted", halted, 1'b0);
    chk("arst_errs", {err_ovf, err_unf}, 2'b00);
    $display("async reset: next_pc=%0h sp_depth=%0d", next_pc, sp_depth);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
